// File: rtl/wallace_mult_arbiter.sv
// Round-robin arbiter that time-shares one 4x4 Wallace tree multiplier among N_REQ requesters.
// Operands are registered before the tree and the product is registered after it.
module wallace_mult_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [4*N_REQ-1:0] req_a,
  input  logic [4*N_REQ-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [7:0]         rsp_product,
  output logic [15:0]        op_count,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StMul, StResp} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, id_q;
  logic [3:0]        a_q, b_q;

  logic [N_REQ-1:0]  mask, hi, pool, grant;
  logic [ID_W-1:0]   win_id;
  logic [3:0]        win_a, win_b;
  logic              found;

  // Requesters above last_grant take precedence; otherwise wrap to the lowest valid index.
  always_comb begin
    mask  = '0;
    grant = '0;
    win_id = '0;
    win_a = '0;
    win_b = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      mask[i] = (i > 32'(last_grant_q));
    end
    hi   = req_valid & mask;
    pool = (hi != '0) ? hi : req_valid;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && pool[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        win_id   = ID_W'(i);
        win_a    = req_a[4*i +: 4];
        win_b    = req_b[4*i +: 4];
      end
    end
  end

  // Wallace tree: partial products, one 4:3 reduction stage, one 3:2 stage, final adder.
  logic [3:0][3:0] pp;
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        pp[i][j] = b_q[i] & a_q[j];
      end
    end
  end

  logic s13, c13, s14, c14;
  logic s22, c22, s23, c23, s24, c24, s25, c25;
  logic [7:0] mul_x, mul_y;

  assign {c13, s13} = {1'b0, pp[0][3]} + {1'b0, pp[1][2]};
  assign {c14, s14} = {1'b0, pp[1][3]} + {1'b0, pp[2][2]};
  assign {c22, s22} = {1'b0, pp[0][2]} + {1'b0, pp[1][1]} + {1'b0, pp[2][0]};
  assign {c23, s23} = {1'b0, s13} + {1'b0, pp[2][1]} + {1'b0, pp[3][0]};
  assign {c24, s24} = {1'b0, s14} + {1'b0, pp[3][1]} + {1'b0, c13};
  assign {c25, s25} = {1'b0, pp[2][3]} + {1'b0, pp[3][2]} + {1'b0, c14};

  assign mul_x = {1'b0, pp[3][3], s25, s24, s23, s22, pp[0][1], pp[0][0]};
  assign mul_y = {1'b0, c25, c24, c23, c22, 1'b0, pp[1][0], 1'b0};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant != '0) state_d = StMul;
      StMul:   state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Gated by rst so no grant is offered while reset is held.
  assign req_ready = (state_q == StIdle && !rst) ? grant : '0;
  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= ID_W'(N_REQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      rsp_product  <= '0;
      rsp_id       <= '0;
      op_count     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && grant != '0) begin
        a_q          <= win_a;
        b_q          <= win_b;
        id_q         <= win_id;
        last_grant_q <= win_id;
      end
      if (state_q == StMul) begin
        rsp_product <= mul_x + mul_y;
        rsp_id      <= id_q;
      end
      if (rsp_valid && rsp_ready && op_count != 16'hFFFF) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/wallace_mult_arbiter.md
# wallace_mult_arbiter

Round-robin arbiter and sequencer that shares one combinational 4x4 Wallace tree multiplier among N_REQ requesters. It accepts one operand pair at a time over a valid/ready handshake, registers the operands into the multiplier, and captures the 8-bit product. It returns the product with the requester's index over a second valid/ready handshake. It sits between the client blocks and the multiplier datapath; the multiplier itself is instantiated unchanged inside this block.

## Interface
- N_REQ, 4, number of requesters; legal range 2..8
- ID_W, 3, width of rsp_id; must satisfy 2^ID_W >= N_REQ
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- req_valid  input  N_REQ  per-requester request valid
- req_ready  output  N_REQ  per-requester accept; at most one bit set
- req_a  input  4*N_REQ  operand A of requester i at [4*i+3:4*i]
- req_b  input  4*N_REQ  operand B of requester i at [4*i+3:4*i]
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  ID_W  index of the requester that owns the result
- rsp_product  output  8  unsigned product A*B
- op_count  output  16  number of completed responses; saturates at 16'hFFFF
- busy  output  1  high in any state other than IDLE

## Operation
- The FSM has three states.
  - IDLE: req_ready is the one-hot grant of the round-robin winner among the set req_valid bits. Transition to MUL on that handshake: latch the winner's A, B and index, and set last_grant to the winner. If no valid bit is set, req_ready is 0 and the FSM stays in IDLE.
  - MUL: the latched operands drive the multiplier. At the clock edge, capture the product into rsp_product and the index into rsp_id, then transition to RESP.
  - RESP: rsp_valid=1. On rsp_valid&rsp_ready, transition to IDLE and increment op_count (saturating). Otherwise hold; rsp_product and rsp_id must stay stable.
- Round-robin search starts at (last_grant+1) mod N_REQ and scans upward with wrap-around. The first requester with valid set wins.
- req_ready is 0 in MUL and RESP. A requester must hold valid, A and B stable until it sees its ready bit. Deasserting valid before the grant withdraws the request with no side effects.
- req_ready depends combinationally on req_valid. No combinational path exists from rsp_ready to req_ready.
- The product is unsigned and 8 bits; 15*15=225 fits, so no overflow handling is needed.
- Reset values: state=IDLE, last_grant=N_REQ-1 (requester 0 has first priority), rsp_valid=0, rsp_id=0, rsp_product=0, op_count=0, busy=0, req_ready=0 while rst=1.
- Reset mid-operation aborts the in-flight operation immediately. No response is produced and op_count is unchanged from its reset value of 0.

## Timing
- Cycle t: request handshake.
- Cycle t+1: MUL.
- Cycle t+2: rsp_valid=1 with product. Latency from handshake to result is 2 cycles.
- Cycle t+2, if rsp_ready=1: the response handshake completes. The next request can be accepted at t+3.
- Peak throughput: one operation per 3 cycles. With rsp_ready held low, the FSM stays in RESP indefinitely.
- op_count updates on the edge that completes the response handshake. It is visible the following cycle.
- busy=1 in MUL and RESP.
- The multiplier's combinational path is bounded by registers on both sides (latched operands to rsp_product).

## Test plan
- Single request, requester 2, A=3, B=5, rsp_ready=1:
  - req_ready=4'b0100 in the same cycle.
  - rsp_valid=1 two cycles later with rsp_product=15, rsp_id=2.
  - op_count=1 afterwards.
- All four requesters valid from reset, each with A=i+1, B=i+2, held until granted:
  - Grants occur in order 0,1,2,3, three cycles apart.
  - Products are 2, 6, 12, 20.
- Backpressure: A=15, B=15 with rsp_ready=0 for 10 cycles:
  - rsp_valid stays 1, rsp_product=225, and all req_ready=0 throughout.
  - Raising rsp_ready completes the response in one cycle.
- Fairness: requesters 0 and 1 continuously valid:
  - Grants alternate 0,1,0,1.
  - No requester is granted twice in a row while another is valid.
- Reset in MUL and again in RESP:
  - All outputs return to their reset values asynchronously.
  - No rsp_valid pulse for the aborted operation.
  - After release, requester 0 has first priority.
- Exhaustive sweep of all 256 A/B pairs through requester 1:
  - Every rsp_product equals A*B.
  - op_count=256 at the end.
